obstacle_scheduler: RTL



---
 rtl/obstacle_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obstacle_scheduler: moves, retires and spawns the four falling obstacles |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module obstacle_scheduler #(
  parameter int          X_W       = 9,
  parameter int          Y_W       = 11,
  parameter int          FIELD_H   = 1080,
  parameter int          X_SPAN    = 176,
  parameter int          SPAWN_GAP = 8,
  parameter int          STEP      = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           tick,
  input  logic           clear,
  output logic [X_W-1:0] dong1x,
  output logic [X_W-1:0] dong2x,
  output logic [X_W-1:0] dong3x,
  output logic [X_W-1:0] dong4x,
  output logic [Y_W-1:0] dong1y,
  output logic [Y_W-1:0] dong2y,
  output logic [Y_W-1:0] dong3y,
  output logic [Y_W-1:0] dong4y,
  output logic [3:0]     active,
  output logic [2:0]     level,
  output logic [7:0]     spawn_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FREEZE = 2'd2;

  localparam int             GAP_W    = $clog2(SPAWN_GAP);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SPAWN_GAP - 1);
  localparam logic [15:0]    SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [X_W-1:0] SPAN     = X_W'(X_SPAN);
  localparam logic [Y_W:0]   LIMIT    = (Y_W+1)'(FIELD_H);

  logic [1:0]       state;
  logic [15:0]      lfsr;
  logic [GAP_W-1:0] gap;
  logic [X_W-1:0]   xs [4];
  logic [Y_W-1:0]   ys [4];

  logic [Y_W:0]     speed;
  logic [Y_W:0]     y_sum [4];
  logic [3:0]       retire;
  logic [3:0]       free;
  logic [3:0]       sel;
  logic             spawn_try;
  logic             spawn_ok;
  logic [X_W-1:0]   r_x;
  logic [X_W-1:0]   spawn_x;
  logic [7:0]       cnt_inc;
  logic             level_up;
  logic [15:0]      lfsr_next;

  // Sums are one bit wider than y so the field-exit compare cannot wrap.
  assign speed = (Y_W+1)'(STEP) + {{(Y_W-2){1'b0}}, level};

  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign y_sum[i]  = {1'b0, ys[i]} + speed;
    assign retire[i] = active[i] && (y_sum[i] >= LIMIT);
  end

  // Eligibility is taken from the pre-tick flags, so a slot retiring now stays empty.
  assign free      = ~active;
  assign sel       = free & (~free + 4'd1);
  assign spawn_try = (gap == GAP_MAX);
  assign spawn_ok  = spawn_try && (free != 4'd0);

  assign r_x       = X_W'(lfsr[7:0]);
  assign spawn_x   = (r_x < SPAN) ? r_x : (r_x - SPAN);
  assign cnt_inc   = (spawn_cnt == 8'hFF) ? 8'hFF : (spawn_cnt + 8'd1);
  assign level_up  = (spawn_cnt != 8'hFF) && (cnt_inc[3:0] == 4'd0) && (level != 3'd7);

  // Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      gap       <= '0;
      active    <= '0;
      level     <= '0;
      spawn_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else if (clear) begin
      state     <= S_IDLE;
      gap       <= '0;
      active    <= '0;
      level     <= '0;
      spawn_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE:   if (run)  state <= S_RUN;
        S_RUN:    if (!run) state <= S_FREEZE;
        S_FREEZE: if (run)  state <= S_RUN;
        default:            state <= S_IDLE;
      endcase

      if (state == S_RUN && tick) begin
        lfsr <= lfsr_next;
        if (!spawn_try) begin
          gap <= gap + GAP_W'(1);
        end else if (spawn_ok) begin
          gap       <= '0;
          spawn_cnt <= cnt_inc;
          if (level_up) level <= level + 3'd1;
        end

        for (int i = 0; i < 4; i++) begin
          if (spawn_ok && sel[i]) begin
            active[i] <= 1'b1;
            xs[i]     <= spawn_x;
            ys[i]     <= '0;
          end else if (retire[i]) begin
            active[i] <= 1'b0;
            xs[i]     <= '0;
            ys[i]     <= '0;
          end else if (active[i]) begin
            ys[i]     <= y_sum[i][Y_W-1:0];
          end
        end
      end
    end
  end

  assign dong1x = xs[0];
  assign dong2x = xs[1];
  assign dong3x = xs[2];
  assign dong4x = xs[3];
  assign dong1y = ys[0];
  assign dong2y = ys[1];
  assign dong3y = ys[2];
  assign dong4y = ys[3];

endmodule
`default_nettype wire
